// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one main-memory port between the instruction cache (read-only) and
// the data cache (read/write). One access is in flight at a time. A granted
// access waits a fixed LATENCY clock edges, then completes with a one-cycle
// response. When both caches ask at once, the one that was not served last
// wins. The loser keeps its request up and is served next.
//
// Main memory has a combinational read (mem_rdata_i follows mem_addr_o) and a
// synchronous write (commits on the edge that ends the mem_we_o pulse).
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   ic_req_i     icache read request, level, held until ic_ready_o
//   ic_addr_i    icache line address
//   dc_req_i     dcache request, level, held until dc_ready_o / dc_wack_o
//   dc_we_i      dcache request is a write
//   dc_addr_i    dcache line address
//   dc_wdata_i   dcache write line
//   rdata_o      returned line, valid while ic_ready_o or dc_ready_o is high
//   ic_ready_o   one-cycle pulse, icache read complete
//   dc_ready_o   one-cycle pulse, dcache read complete
//   dc_wack_o    one-cycle pulse, dcache write committed
//   busy_o       high while an access is in WAIT or RESP
//   mem_addr_o   registered main-memory address
//   mem_wdata_o  registered main-memory write line
//   mem_we_o     main-memory write enable, one-cycle pulse
//   mem_rdata_i  main-memory combinational read data
//
// LATENCY must lie in 1..15 (the wait counter is 4 bits wide).
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic [LINE_W-1:0] rdata_o,
    output logic              ic_ready_o,
    output logic              dc_ready_o,
    output logic              dc_wack_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } req_id_t;

    state_t      state_q,      state_d;
    req_id_t     last_grant_q, last_grant_d;
    req_id_t     gnt_id_q,     gnt_id_d;
    logic        gnt_we_q,     gnt_we_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [LINE_W-1:0] rdata_q,     rdata_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              ic_ready_q,  ic_ready_d;
    logic              dc_ready_q,  dc_ready_d;
    logic              dc_wack_q,   dc_wack_d;
    logic              mem_we_q,    mem_we_d;
    logic              busy_q,      busy_d;

    logic              pick_dc;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves one unassigned; that is what keeps this block latch-free.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        gnt_we_d     = gnt_we_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ic_ready_d   = 1'b0;
        dc_ready_d   = 1'b0;
        dc_wack_d    = 1'b0;
        mem_we_d     = 1'b0;
        pick_dc      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ic_req_i || dc_req_i) begin
                    // A lone requester always wins; on a tie the dcache wins
                    // only if the icache was served last.
                    pick_dc      = dc_req_i && (!ic_req_i || last_grant_q == ICACHE);
                    gnt_id_d     = pick_dc ? DCACHE : ICACHE;
                    last_grant_d = pick_dc ? DCACHE : ICACHE;
                    gnt_we_d     = pick_dc && dc_we_i;
                    mem_addr_d   = pick_dc ? dc_addr_i : ic_addr_i;
                    // Only the dcache supplies write data; an icache grant
                    // leaves the previous write line in place.
                    if (pick_dc) begin
                        mem_wdata_d = dc_wdata_i;
                    end
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_RESP;
                    // Pulses are registered, so they are raised here and are
                    // visible for exactly the RESP cycle.
                    if (gnt_we_q) begin
                        dc_wack_d = 1'b1;
                        mem_we_d  = 1'b1;
                    end else begin
                        rdata_d = mem_rdata_i;
                        if (gnt_id_q == DCACHE) begin
                            dc_ready_d = 1'b1;
                        end else begin
                            ic_ready_d = 1'b1;
                        end
                    end
                end
            end

            S_RESP: begin
                // No acceptance here: a request seen on this edge is only
                // considered on the following one, from IDLE.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= ICACHE;
            gnt_id_q     <= ICACHE;
            gnt_we_q     <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ic_ready_q   <= 1'b0;
            dc_ready_q   <= 1'b0;
            dc_wack_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            gnt_we_q     <= gnt_we_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ic_ready_q   <= ic_ready_d;
            dc_ready_q   <= dc_ready_d;
            dc_wack_q    <= dc_wack_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign ic_ready_o  = ic_ready_q;
    assign dc_ready_o  = dc_ready_q;
    assign dc_wack_o   = dc_wack_q;
    assign busy_o      = busy_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters: u_dut (LATENCY=5) is followed cycle by cycle by a
// transaction-level model (grant edge, response edge, next free edge, reference
// memory), and u_dut1 (LATENCY=1) gets directed checks only. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int LAT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          ic_req, dc_req, dc_we;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [LW-1:0] dc_wdata;
    logic [LW-1:0] rdata, mem_wdata, mem_rdata;
    logic          ic_ready, dc_ready, dc_wack, busy, mem_we;
    logic [AW-1:0] mem_addr;

    logic          ic1_req, dc1_req, dc1_we;
    logic [AW-1:0] ic1_addr, dc1_addr;
    logic [LW-1:0] dc1_wdata;
    logic [LW-1:0] rdata1, mem1_wdata, mem1_rdata;
    logic          ic1_ready, dc1_ready, dc1_wack, busy1, mem1_we;
    logic [AW-1:0] mem1_addr;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr),
        .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
        .rdata_o(rdata), .ic_ready_o(ic_ready), .dc_ready_o(dc_ready), .dc_wack_o(dc_wack),
        .busy_o(busy), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .ic_req_i(ic1_req), .ic_addr_i(ic1_addr),
        .dc_req_i(dc1_req), .dc_we_i(dc1_we), .dc_addr_i(dc1_addr), .dc_wdata_i(dc1_wdata),
        .rdata_o(rdata1), .ic_ready_o(ic1_ready), .dc_ready_o(dc1_ready), .dc_wack_o(dc1_wack),
        .busy_o(busy1), .mem_addr_o(mem1_addr), .mem_wdata_o(mem1_wdata), .mem_we_o(mem1_we),
        .mem_rdata_i(mem1_rdata)
    );

    // ---------------------------------------------------------------- memory
    // Unwritten lines read as a fixed pattern derived from the address.
    function automatic logic [LW-1:0] base_line(input logic [7:0] a);
        if (a == 8'h40) return {16{8'hA5}};
        return {4{24'hC0FFEE, a}};
    endfunction

    bit [LW-1:0] mem_line [256];
    bit          mem_wr   [256];

    assign mem_rdata  = mem_wr[mem_addr[7:0]] ? mem_line[mem_addr[7:0]] : base_line(mem_addr[7:0]);
    assign mem1_rdata = base_line(mem1_addr[7:0]);

    always @(posedge clk) begin
        if (mem_we) begin
            mem_line[mem_addr[7:0]] <= mem_wdata;
            mem_wr[mem_addr[7:0]]   <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- checking
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Transaction view: an access granted at edge T0 responds at T0+LAT,
    // a write lands in memory at T0+LAT+1, and the next grant may happen at
    // T0+LAT+2 at the earliest.
    int            cyc        = 0;
    bit            seen_reset = 1'b0;
    int            m_resp     = -1;
    int            m_free     = 0;
    bit            m_dc, m_we, m_last_dc;
    logic [AW-1:0] x_addr;
    logic [LW-1:0] x_rdata, x_wdata;
    bit [LW-1:0]   ref_line [256];
    bit            ref_wr   [256];

    always @(posedge clk) begin
        bit pick_dc;
        cyc++;
        if (m_resp >= 0 && cyc == m_resp + 1 && m_we) begin
            ref_line[x_addr[7:0]] = x_wdata;
            ref_wr[x_addr[7:0]]   = 1'b1;
        end
        if (reset) begin
            seen_reset = 1'b1;
            m_resp     = -1;
            m_free     = cyc + 1;
            m_last_dc  = 1'b0;
            m_we       = 1'b0;
            x_rdata    = '0;
            x_addr     = '0;
            x_wdata    = '0;
        end else if (seen_reset) begin
            if (cyc == m_resp && !m_we)
                x_rdata = ref_wr[x_addr[7:0]] ? ref_line[x_addr[7:0]] : base_line(x_addr[7:0]);
            if (cyc >= m_free && (ic_req || dc_req)) begin
                pick_dc   = dc_req && (!ic_req || !m_last_dc);
                m_dc      = pick_dc;
                m_we      = pick_dc && dc_we;
                m_last_dc = pick_dc;
                x_addr    = pick_dc ? dc_addr : ic_addr;
                if (pick_dc) x_wdata = dc_wdata;
                m_resp    = cyc + LAT;
                m_free    = cyc + LAT + 2;
            end
        end
    end

    always @(negedge clk) begin
        bit in_resp;
        if (seen_reset) begin
            in_resp = (m_resp >= 0 && cyc == m_resp);
            check("busy",      LW'(busy),     LW'(m_resp >= 0 && cyc >= m_resp - LAT && cyc <= m_resp));
            check("ic_ready",  LW'(ic_ready), LW'(in_resp && !m_dc));
            check("dc_ready",  LW'(dc_ready), LW'(in_resp && m_dc && !m_we));
            check("dc_wack",   LW'(dc_wack),  LW'(in_resp && m_we));
            check("mem_we",    LW'(mem_we),   LW'(in_resp && m_we));
            check("mem_addr",  LW'(mem_addr), LW'(x_addr));
            check("mem_wdata", mem_wdata,     x_wdata);
            check("rdata",     rdata,         x_rdata);
        end
    end

    // ---------------------------------------------------------------- stimulus
    // which: 0 ic_ready, 1 dc_ready, 2 dc_wack, 3 ic1_ready
    task automatic wait_pulse(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && ic_ready) || (which == 1 && dc_ready) ||
                (which == 2 && dc_wack)  || (which == 3 && ic1_ready)) begin
                at = cyc;
                return;
            end
        end
        n_vec++;
        n_miss++;
        $display("FAIL pulse_timeout: pulse %0d not seen within %0d cycles", which, budget);
    endtask

    int       t0, at, got, guard, wcnt;
    bit [3:0] order;

    initial begin
        reset   = 1'b1;
        ic_req  = 1'b0; ic_addr  = '0;
        dc_req  = 1'b0; dc_we    = 1'b0; dc_addr = '0; dc_wdata = '0;
        ic1_req = 1'b0; ic1_addr = '0;
        dc1_req = 1'b0; dc1_we   = 1'b0; dc1_addr = '0; dc1_wdata = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_busy",     LW'(busy),     '0);
        check("rst_rdata",    rdata,         '0);
        check("rst_mem_addr", LW'(mem_addr), '0);
        check("rst_pulses",   LW'({ic_ready, dc_ready, dc_wack, mem_we}), '0);
        reset = 1'b0;

        // Single icache read of line 0x40.
        ic_addr = 32'h40; ic_req = 1'b1; t0 = cyc + 1;
        wait_pulse(0, 20, at);
        check("ic_read_latency", LW'(at - t0), 128'd5);
        check("ic_read_rdata",   rdata, {16{8'hA5}});
        check("ic_read_no_dc",   LW'({dc_ready, dc_wack}), '0);
        ic_req = 1'b0;
        repeat (2) @(negedge clk);

        // dcache write 0x80, then a read of the same line: the request stays
        // high across RESP with dc_we dropped, so it is a new read at T0+7.
        dc_addr = 32'h80; dc_wdata = 128'h1234; dc_we = 1'b1; dc_req = 1'b1; t0 = cyc + 1;
        wait_pulse(2, 20, at);
        check("wr_wack_latency", LW'(at - t0), 128'd5);
        check("wr_mem_we",       LW'(mem_we),  128'd1);
        check("wr_mem_wdata",    mem_wdata,    128'h1234);
        dc_we = 1'b0;
        wait_pulse(1, 30, at);
        check("rd_after_wr_latency", LW'(at - t0), 128'd12);
        check("rd_after_wr_rdata",   rdata,        128'h1234);
        check("wr_committed",        mem_line[8'h80], 128'h1234);
        dc_req = 1'b0;

        // Simultaneous requests straight out of reset: dcache first.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        ic_addr = 32'h44; dc_addr = 32'h48; ic_req = 1'b1; dc_req = 1'b1; t0 = cyc + 1;
        wait_pulse(1, 20, at);
        check("tie_dc_first",   LW'(at - t0), 128'd5);
        check("tie_dc_rdata",   rdata,        base_line(8'h48));
        dc_req = 1'b0;
        wait_pulse(0, 20, at);
        check("tie_ic_second",  LW'(at - t0), 128'd12);
        check("tie_ic_rdata",   rdata,        base_line(8'h44));
        ic_req = 1'b0;
        repeat (2) @(negedge clk);

        // Both requesters continuously active for four accesses; addresses are
        // scrambled mid-WAIT and restored before the next grant.
        ic_addr = 32'h50; dc_addr = 32'h60; ic_req = 1'b1; dc_req = 1'b1;
        got = 0; guard = 0; wcnt = 0; order = '0;
        while (got < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (!ic_req) ic_req = 1'b1;
            if (!dc_req) dc_req = 1'b1;
            if (ic_ready || dc_ready) begin
                order = {order[2:0], dc_ready};
                check("rr_rdata", rdata, base_line(ic_ready ? 8'h50 : 8'h60));
                if (ic_ready) ic_req = 1'b0;
                else          dc_req = 1'b0;
                ic_addr = 32'h50; dc_addr = 32'h60; wcnt = 0;
                got++;
            end else if (busy) begin
                wcnt++;
                if (wcnt == 2) begin
                    ic_addr = 32'hEE; dc_addr = 32'hEE;
                end
            end
        end
        check("rr_order_DIDI", LW'(order), 128'b1010);
        ic_req = 1'b0; dc_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during WAIT of a dcache write aborts it.
        dc_addr = 32'h90; dc_wdata = 128'hDEAD; dc_we = 1'b1; dc_req = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_busy_before", LW'(busy), 128'd1);
        reset = 1'b1; dc_req = 1'b0; dc_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy_after", LW'(busy), '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_write", LW'({mem_we, dc_wack}), '0);
        end
        check("abort_mem_unchanged", LW'(mem_wr[8'h90]), '0);
        dc_addr = 32'h90; dc_req = 1'b1; t0 = cyc + 1;
        wait_pulse(1, 20, at);
        check("abort_next_latency", LW'(at - t0), 128'd5);
        check("abort_next_rdata",   rdata,        base_line(8'h90));
        dc_req = 1'b0;
        repeat (2) @(negedge clk);

        // LATENCY=1 build: response one edge after grant, next grant at T0+3.
        ic1_addr = 32'h40; ic1_req = 1'b1; t0 = cyc + 1;
        wait_pulse(3, 10, at);
        check("lat1_latency", LW'(at - t0), 128'd1);
        check("lat1_rdata",   rdata1,       {16{8'hA5}});
        check("lat1_busy",    LW'(busy1),   128'd1);
        ic1_req = 1'b0;
        @(negedge clk);
        check("lat1_idle_gap", LW'(busy1), '0);
        ic1_req = 1'b1;
        wait_pulse(3, 10, at);
        check("lat1_next_grant", LW'(at - t0), 128'd4);
        ic1_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences every access to main memory and shares it between the instruction cache (read-only) and the data cache (read/write).
- Round-robin arbitration with a fixed, parameterised access latency.
- Simultaneous icache/dcache requests are queued and both served, never dropped.
- Sits between both caches and a main-memory array that has a combinational read and a synchronous write.

Parameters:
- ADDR_W, 32, memory address width in bits.
- LINE_W, 128, cache line width in bits.
- LATENCY, 5, clock edges from request acceptance to response pulse; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ic_req  in  1  icache read request, level, held until ic_ready
- ic_addr  in  ADDR_W  icache line address
- dc_req  in  1  dcache request, level, held until dc_ready or dc_wack
- dc_we  in  1  dcache request is a write
- dc_addr  in  ADDR_W  dcache line address
- dc_wdata  in  LINE_W  dcache write line
- rdata  out  LINE_W  returned line, valid while ic_ready or dc_ready is high
- ic_ready  out  1  one-cycle pulse, icache read complete
- dc_ready  out  1  one-cycle pulse, dcache read complete
- dc_wack  out  1  one-cycle pulse, dcache write committed
- busy  out  1  high in WAIT and RESP
- mem_addr  out  ADDR_W  address to main memory, registered
- mem_wdata  out  LINE_W  write line to main memory, registered
- mem_we  out  1  main-memory write enable, one-cycle pulse
- mem_rdata  in  LINE_W  main-memory combinational read data

Behaviour:
- Reset (sync) values:
  - state=IDLE, all pulses=0, busy=0.
  - rdata, mem_addr and mem_wdata = 0.
  - last_grant=ICACHE, so the first tie goes to dcache.
- FSM states: IDLE, WAIT, RESP.
- IDLE, at each edge:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not last_grant.
- On grant (edge T0):
  - Latch into registers: granted id, op = dc_we (icache always read), mem_addr, mem_wdata.
  - Update last_grant; cnt = LATENCY-1; go to WAIT.
  - Changes to the request inputs after T0 are ignored for this access.
- WAIT:
  - If cnt != 0: decrement cnt, stay in WAIT.
  - If cnt == 0: go to RESP at edge T0+LATENCY.
  - On that transition a read captures rdata <= mem_rdata.
- RESP (exactly one cycle, from edge T0+LATENCY):
  - Read: the granted requester's ready pulse is high.
  - Write: dc_wack and mem_we are high, and memory commits at edge T0+LATENCY+1.
  - Then go to IDLE.
- Pulses:
  - Never more than one of ic_ready / dc_ready / dc_wack high at a time.
  - Each pulse lasts exactly one cycle.
  - rdata holds its value until the next read completes; writes do not alter rdata.
- Request handshake:
  - Requesters must deassert req by edge T0+LATENCY+1.
  - No acceptance occurs in RESP, so the earliest next grant is edge T0+LATENCY+2.
  - A request still high at that edge is a new request.
- Fairness: with both requesters continuously active, grants alternate strictly. Worst-case wait is 2*(LATENCY+2) cycles.
- Reset mid-operation: the access is aborted with no write commit (mem_we stays 0), no pulse is issued, and the FSM returns to IDLE.
- busy is a registered decode: high exactly while state != IDLE.

Test Plan:
- LATENCY=5, ic_req=1 with ic_addr=0x40, memory line 0x40 = 0xA5..A5, accepted at T0 -> ic_ready single pulse at edge T0+5, rdata=0xA5..A5, dc_ready=dc_wack=0.
- dcache write addr 0x80, data 0x1234, then dcache read 0x80 -> mem_we pulse at T0+5 only, dc_wack at T0+5; the read returns 0x1234 with dc_ready at T1+5, where T1 >= T0+7.
- ic_req and dc_req rise at the same edge from reset -> dcache granted first (dc_ready at T0+5); icache granted at T0+7 (ic_ready at T0+12).
- Both requests held high for 4 accesses (each requester reasserting after its pulse) -> grant order D, I, D, I; ic_addr/dc_addr changed mid-WAIT do not affect mem_addr.
- Reset asserted during WAIT of a dcache write -> mem_we and dc_wack never pulse, memory unchanged, busy=0 the next cycle, next request served normally.
- LATENCY=1 build, single icache read accepted at T0 -> ic_ready at T0+1, next grant possible at T0+3.
